// File: rtl/ip_fk_stage.sv
// DES initial permutation plus one Feistel round with a hardwired subkey (K1 or K10),
// registered once; also exposes the raw f-function output.
module ip_fk_stage #(
  parameter logic [48:1] K1  = 48'h1B02EFFC7072,
  parameter logic [48:1] K10 = 48'hB1F347BA464F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [64:1] in,
  input  logic        ip_en,
  input  logic        key_sel,
  output logic        out_valid,
  output logic [64:1] out,
  output logic [32:1] f_out
);

  // S-box contents, 64 nibbles each in row-major order (row*16 + col), entry 0 in the top nibble.
  localparam logic [255:0] S1 = 256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D;
  localparam logic [255:0] S2 = 256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9;
  localparam logic [255:0] S3 = 256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C;
  localparam logic [255:0] S4 = 256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E;
  localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453;
  localparam logic [255:0] S6 = 256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D;
  localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C;
  localparam logic [255:0] S8 = 256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B;

  // Internal vectors are [N-1:0]; DES bit k sits at index N-k, so the tables below are pre-converted.
  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    return {d[6], d[14], d[22], d[30], d[38], d[46], d[54], d[62],
            d[4], d[12], d[20], d[28], d[36], d[44], d[52], d[60],
            d[2], d[10], d[18], d[26], d[34], d[42], d[50], d[58],
            d[0], d[8],  d[16], d[24], d[32], d[40], d[48], d[56],
            d[7], d[15], d[23], d[31], d[39], d[47], d[55], d[63],
            d[5], d[13], d[21], d[29], d[37], d[45], d[53], d[61],
            d[3], d[11], d[19], d[27], d[35], d[43], d[51], d[59],
            d[1], d[9],  d[17], d[25], d[33], d[41], d[49], d[57]};
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] r);
    return {r[0],  r[31], r[30], r[29], r[28], r[27],
            r[28], r[27], r[26], r[25], r[24], r[23],
            r[24], r[23], r[22], r[21], r[20], r[19],
            r[20], r[19], r[18], r[17], r[16], r[15],
            r[16], r[15], r[14], r[13], r[12], r[11],
            r[12], r[11], r[10], r[9],  r[8],  r[7],
            r[8],  r[7],  r[6],  r[5],  r[4],  r[3],
            r[4],  r[3],  r[2],  r[1],  r[0],  r[31]};
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  // Row comes from the outer bits {b1,b6}, column from b2..b5.
  function automatic logic [3:0] sbox_lu(input logic [255:0] tbl, input logic [5:0] b);
    logic [5:0] idx;
    logic [7:0] lsb;
    idx = {b[5], b[0], b[4:1]};
    lsb = 8'd252 - {idx, 2'b00};
    return tbl[lsb +: 4];
  endfunction

  logic [63:0] blk;
  logic [31:0] l_half;
  logic [31:0] r_half;
  logic [47:0] ex;
  logic [31:0] sb_out;
  logic [31:0] f_val;

  logic        out_valid_d, out_valid_q;
  logic [64:1] out_d, out_q;
  logic [32:1] f_out_d, f_out_q;

  always_comb begin
    blk    = ip_en ? ip_perm(in) : in;
    l_half = blk[63:32];
    r_half = blk[31:0];
    ex     = e_expand(r_half) ^ (key_sel ? K10 : K1);
    sb_out = {sbox_lu(S1, ex[47:42]), sbox_lu(S2, ex[41:36]),
              sbox_lu(S3, ex[35:30]), sbox_lu(S4, ex[29:24]),
              sbox_lu(S5, ex[23:18]), sbox_lu(S6, ex[17:12]),
              sbox_lu(S7, ex[11:6]),  sbox_lu(S8, ex[5:0])};
    f_val  = p_perm(sb_out);
  end

  always_comb begin
    out_valid_d = 1'b0;
    out_d       = out_q;
    f_out_d     = f_out_q;
    if (in_valid) begin
      out_valid_d = 1'b1;
      out_d       = {r_half, l_half ^ f_val};
      f_out_d     = f_val;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= 64'h0;
      f_out_q     <= 32'h0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      f_out_q     <= f_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign f_out     = f_out_q;

endmodule

// File: tb/tb_ip_fk_stage.sv
// Directed and randomised checks of ip_fk_stage against hand values and a table-driven DES round model.
module tb_ip_fk_stage;

  localparam logic [47:0] TB_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] TB_K10 = 48'hB1F347BA464F;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [64:1] in;
  logic        ip_en;
  logic        key_sel;
  logic        out_valid;
  logic [64:1] out;
  logic [32:1] f_out;

  int errors = 0;
  int checks = 0;

  ip_fk_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .ip_en(ip_en),
    .key_sel(key_sel), .out_valid(out_valid), .out(out), .f_out(f_out)
  );

  always #5 clk = ~clk;

  // Standard DES tables, 1-indexed bit numbers from the MSB.
  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int e_t [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int sb_t [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] m_ip(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = d[64-ip_t[i]];
    return r;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    int six, row, col;
    e = '0;
    p = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
    e = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = int'((e >> (42 - 6*b)) & 48'h3F);
      row = ((six >> 5) & 1) * 2 + (six & 1);
      col = (six >> 1) & 15;
      s   = (s << 4) | 32'(sb_t[b][row*16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-p_t[i]];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] x_m, exp_out;
  logic [31:0] f_m, exp_f;
  logic        exp_v;

  initial begin
    rst = 1'b1; in_valid = 1'b1; in = 64'h0123456789ABCDEF; ip_en = 1'b1; key_sel = 1'b0;
    step();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_out",   out,            64'h0);
    chk("rst_f",     64'(f_out),     64'h0);

    rst = 1'b0;
    step();
    chk("r1_valid", 64'(out_valid), 64'h1);
    chk("r1_f",     64'(f_out),     64'h00000000234AA9BB);
    chk("r1_out",   out,            64'hF0AAF0AAEF4A6544);

    in = 64'h0; ip_en = 1'b0; key_sel = 1'b1;
    step();
    chk("k10_valid", 64'(out_valid), 64'h1);
    chk("k10_f",     64'(f_out),     64'h000000009121763C);
    chk("k10_out",   out,            64'h000000009121763C);

    in_valid = 1'b0; in = 64'hFFFF0000FFFF0000; key_sel = 1'b0;
    step();
    chk("idle_valid", 64'(out_valid), 64'h0);
    chk("idle_out",   out,            64'h000000009121763C);
    chk("idle_f",     64'(f_out),     64'h000000009121763C);

    in_valid = 1'b1; in = 64'hCC00CCFFF0AAF0AA; ip_en = 1'b0; key_sel = 1'b0;
    step();
    chk("byp_valid", 64'(out_valid), 64'h1);
    chk("byp_f",     64'(f_out),     64'h00000000234AA9BB);
    chk("byp_out",   out,            64'hF0AAF0AAEF4A6544);

    rst = 1'b1; in = 64'h0; key_sel = 1'b1;
    step();
    chk("rstpri_valid", 64'(out_valid), 64'h0);
    chk("rstpri_out",   out,            64'h0);
    chk("rstpri_f",     64'(f_out),     64'h0);

    rst = 1'b0; in = 64'h0123456789ABCDEF; ip_en = 1'b1; key_sel = 1'b0;
    step();
    chk("post_valid", 64'(out_valid), 64'h1);
    chk("post_f",     64'(f_out),     64'h00000000234AA9BB);
    chk("post_out",   out,            64'hF0AAF0AAEF4A6544);

    exp_out = 64'hF0AAF0AAEF4A6544;
    exp_f   = 32'h234AA9BB;
    for (int n = 0; n < 1000; n++) begin
      in       = {$urandom, $urandom};
      ip_en    = 1'($urandom_range(0, 1));
      key_sel  = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      exp_v    = in_valid;
      if (in_valid) begin
        x_m     = ip_en ? m_ip(in) : in;
        f_m     = m_f(x_m[31:0], key_sel ? TB_K10 : TB_K1);
        exp_f   = f_m;
        exp_out = {x_m[31:0], x_m[63:32] ^ f_m};
      end
      step();
      chk("rnd_valid", 64'(out_valid), 64'(exp_v));
      chk("rnd_f",     64'(f_out),     64'(exp_f));
      chk("rnd_out",   out,            exp_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_fk_stage.md
# ip_fk_stage

Registered DES front-end and round unit. It applies the DES initial permutation (IP) and evaluates one Feistel round with a hardwired round key: K1 for round 1 or K10 for round 10. It sits between the 64-bit data source and the remaining round logic of the fixed-key DES datapath. It also exposes the raw f-function result for checking.

## Interface
Parameters:
- `K1`, default 48'h1B02EFFC7072, round-1 subkey in DES bit order (bit 48 = key bit 1).
- `K10`, default 48'hB1F347BA464F, round-10 subkey, same ordering.

Ports:
- `clk`, input, 1, the single clock; all state updates on its rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `in_valid`, input, 1, a new block is presented this cycle.
- `in`, input, 64 (`[64:1]`), input block; bit 64 is DES bit 1.
- `ip_en`, input, 1; 1 = apply IP to `in`, 0 = `in` is already `{L,R}`.
- `key_sel`, input, 1; 0 = use f_k1 (K1), 1 = use f_k10 (K10).
- `out_valid`, output, 1, `out` and `f_out` hold a result.
- `out`, output, 64 (`[64:1]`), round result `{Ln+1, Rn+1}`.
- `f_out`, output, 32 (`[32:1]`), f(R, K) of the accepted block.

## Operation
- `x = ip_en ? IP(in) : in`, where IP is the standard DES initial permutation table (58,50,…,7). Output bit i is input bit IP[i], 1-indexed from the MSB.
- Split x as `{L[32:1], R[32:1]}`.
- f(R, K) is computed as follows:
  - E expansion of R to 48 bits (standard E table 32,1,2,…,1).
  - XOR with K, where K = `key_sel ? K10 : K1`.
  - 8 standard DES S-boxes, each taking 6 bits to 4 bits. Row = {b1,b6}, column = b2..b5. S1 uses the most-significant 6 bits.
  - Standard P permutation (16,7,20,…,25).
- Round result: `out = {R, L ^ f}`. The halves are not swapped beyond the normal Feistel step; the final R16/L16 swap belongs to the downstream inverse-IP block.
- Store S-box tables as constants, e.g. 64 nibbles per box. Key schedule logic is forbidden; keys come only from the parameters.
- Pure combinational function feeding one register stage. No internal state other than the output registers.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge t appear on `out`/`f_out` with `out_valid=1` after edge t.
- `out_valid` follows `in_valid` with 1-cycle delay. There is no backpressure, so a new block may be accepted every cycle.
- When `in_valid=0` at an edge, `out_valid` goes to 0 and `out`/`f_out` hold their previous values.
- Reset: if `rst=1` at an edge, then `out_valid=0`, `out=64'h0`, `f_out=32'h0`. Reset has priority over a simultaneous `in_valid`, and that block is dropped.
- Reset release: the first block is accepted at the first edge with `rst=0` and `in_valid=1`.
- `ip_en` and `key_sel` are sampled with `in`. Changing them every cycle is legal, with no mixing between consecutive blocks.

## Test plan
- **Round 1 with IP:** reset, then present `in=64'h0123456789ABCDEF`, `ip_en=1`, `key_sel=0`, `in_valid=1`.
  - Required after the next edge: `out_valid=1`, `f_out=32'h234AA9BB`, `out=64'hF0AAF0AAEF4A6544` (IP gives L0=CC00CCFF, R0=F0AAF0AA).
- **f_k10 on zero:** present `in=64'h0`, `ip_en=0`, `key_sel=1`.
  - Required: `f_out=32'h9121763C`, `out=64'h000000009121763C`.
- **IP bypass with K1:** present `in=64'hCC00CCFFF0AAF0AA`, `ip_en=0`, `key_sel=0`.
  - Required: the same `out`/`f_out` as the round-1 scenario.
- **Back-to-back blocks:** present the round-1 block, then the f_k10 block on consecutive cycles.
  - Required: two consecutive valid outputs with the values above, in order, and no gap.
- **Reset priority:** assert `rst` together with `in_valid=1`.
  - Required: `out_valid=0`, `out=0`, `f_out=0` on the next cycle.
  - A block presented in the first cycle after `rst` deasserts must emerge normally.
- **Randomised cross-check:** 1000 random `in` / `ip_en` / `key_sel` combinations compared against a software DES round model using the same K1/K10.
